// File: rtl/muldiv_unit.sv
// Iterative 32x32 multiply / 32/32 divide unit owning the HI/LO registers.
// One bit per cycle: issue edge, 32 CALC edges, one FIX edge that writes HI/LO.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH-1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;

  typedef struct packed {
    logic is_div;
    logic qneg;   // negate product / quotient
    logic rneg;   // negate remainder (sign of dividend)
    logic div0;
  } ctl_t;

  state_e               state_q, state_d;
  ctl_t                 ctl_q, ctl_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                 done_q, done_d;

  logic                 md_op, is_signed, is_div, a_neg, b_neg;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       mul_sum, div_shift;
  logic [WIDTH+1:0]     div_diff;

  assign md_op     = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  assign is_signed = (op == OP_MULT) || (op == OP_DIV);
  assign is_div    = (op == OP_DIV)  || (op == OP_DIVU);
  assign a_neg     = is_signed & a[WIDTH-1];
  assign b_neg     = is_signed & b[WIDTH-1];
  assign a_mag     = a_neg ? -a : a;
  assign b_mag     = b_neg ? -b : b;

  // Multiply: acc = {partial, multiplier}; divide: acc = {remainder, dividend/quotient}
  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign div_shift = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_diff  = {1'b0, div_shift} - {2'b00, opnd_q};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && !flush && md_op) state_d = CALC;
      CALC:    if (flush) state_d = IDLE;
               else if (cnt_q == LAST) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
    done = done_q;
    hi   = hi_q;
    lo   = lo_q;
  end

  always_comb begin
    ctl_d  = ctl_q;
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    opnd_d = opnd_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: if (start && !flush) begin
        if (md_op) begin
          ctl_d.is_div = is_div;
          ctl_d.qneg   = a_neg ^ b_neg;
          ctl_d.rneg   = a_neg;
          ctl_d.div0   = (b == '0);
          acc_d        = {{WIDTH{1'b0}}, is_div ? a_mag : b_mag};
          opnd_d       = is_div ? b_mag : a_mag;
          cnt_d        = '0;
        end else if (op == OP_MTHI) begin
          hi_d = a;
        end else if (op == OP_MTLO) begin
          lo_d = a;
        end
      end
      CALC: if (!flush) begin
        cnt_d = cnt_q + CW'(1);
        if (ctl_q.is_div)
          acc_d = div_diff[WIDTH+1] ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};
        else
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
      end
      FIX: if (!flush) begin
        done_d = 1'b1;
        if (ctl_q.is_div) begin
          // A zero divisor leaves |a| as remainder, so the sign fix restores a itself
          lo_d = ctl_q.div0 ? '1 : (ctl_q.qneg ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
          hi_d = ctl_q.rneg ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        end else begin
          {hi_d, lo_d} = ctl_q.qneg ? -acc_q : acc_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctl_q  <= '0;
      cnt_q  <= '0;
      acc_q  <= '0;
      opnd_q <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      ctl_q  <= ctl_d;
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      opnd_q <= opnd_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      done_q <= done_d;
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed boundary cases plus random ops
// checked against a plain-arithmetic reference model.
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        start, flush;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_hi, exp_lo;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] h, output logic [31:0] l);
    longint      p;
    logic [63:0] u;
    int          sx, sy;
    h = exp_hi;
    l = exp_lo;
    case (o)
      3'd0: begin
        p = longint'($signed(x)) * longint'($signed(y));
        {h, l} = p;
      end
      3'd1: begin
        u = {32'b0, x} * {32'b0, y};
        {h, l} = u;
      end
      3'd2: begin
        sx = x; sy = y;
        if (y == 0) begin h = x; l = 32'hFFFF_FFFF; end
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin h = 0; l = 32'h8000_0000; end
        else begin l = sx / sy; h = sx % sy; end
      end
      3'd3: begin
        if (y == 0) begin h = x; l = 32'hFFFF_FFFF; end
        else begin l = x / y; h = x % y; end
      end
      default: ;
    endcase
  endfunction

  // Issues a MULT/DIV, checks 34-edge latency, busy, result and single-cycle done.
  // inj: try an MTLO while busy, which must be ignored.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input bit inj);
    logic [31:0] eh, el;
    int n;
    bit bz;
    model(o, x, y, eh, el);
    start = 1'b1; op = o; a = x; b = y;
    tick();
    start = 1'b0;
    n = 0; bz = 1'b1;
    while (done !== 1'b1 && n < 60) begin
      bz &= (busy === 1'b1);
      if (inj && n == 5) begin start = 1'b1; op = 3'd5; a = 32'hDEAD_BEEF; end
      else start = 1'b0;
      tick();
      n++;
    end
    start = 1'b0;
    check({tag, "_latency"}, 64'(n), 64'd33);
    check({tag, "_busy_during"}, 64'(bz), 64'd1);
    check({tag, "_busy_after"}, 64'(busy), 64'd0);
    check({tag, "_hi"}, 64'(hi), 64'(eh));
    check({tag, "_lo"}, 64'(lo), 64'(el));
    exp_hi = eh; exp_lo = el;
    tick();
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] rx, ry;
    int          r;
    bit          nodone;

    rst = 1'b0; start = 1'b0; flush = 1'b0; op = 3'd0; a = '0; b = '0;
    exp_hi = 0; exp_lo = 0;
    #3;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    tick();
    rst = 1'b1;
    tick();

    run_op("mult_neg3x7", 3'd0, 32'hFFFF_FFFD, 32'd7, 1'b0);
    check("mult_neg3x7_hi_const", 64'(hi), 64'hFFFF_FFFF);
    check("mult_neg3x7_lo_const", 64'(lo), 64'hFFFF_FFEB);
    run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check("multu_max_hi_const", 64'(hi), 64'hFFFF_FFFE);
    run_op("div_neg7by2", 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check("div_neg7by2_lo_const", 64'(lo), 64'hFFFF_FFFD);
    run_op("divu_7by2", 3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check("divu_7by2_lo_const", 64'(lo), 64'h7FFF_FFFC);
    run_op("divu_by0", 3'd3, 32'd100, 32'd0, 1'b0);
    check("divu_by0_hi_const", 64'(hi), 64'h64);
    run_op("div_by0_neg", 3'd2, 32'hFFFF_FF00, 32'd0, 1'b0);
    run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check("div_ovf_lo_const", 64'(lo), 64'h8000_0000);

    // MTHI / MTLO in idle
    start = 1'b1; op = 3'd4; a = 32'h1234_5678;
    tick();
    start = 1'b0;
    exp_hi = 32'h1234_5678;
    check("mthi_hi", 64'(hi), 64'(exp_hi));
    check("mthi_busy", 64'(busy), 64'd0);
    check("mthi_done", 64'(done), 64'd0);
    start = 1'b1; op = 3'd5; a = 32'hCAFE_0001;
    tick();
    start = 1'b0;
    exp_lo = 32'hCAFE_0001;
    check("mtlo_lo", 64'(lo), 64'(exp_lo));
    check("mtlo_hi_hold", 64'(hi), 64'(exp_hi));

    // MTLO during a busy MULT is dropped
    run_op("mult_mtlo_busy", 3'd0, 32'd1234, 32'hFFFF_0000, 1'b1);

    // Flush in idle beats start, MTHI included
    start = 1'b1; flush = 1'b1; op = 3'd4; a = 32'h5555_AAAA;
    tick();
    start = 1'b0; flush = 1'b0;
    check("idle_flush_hi", 64'(hi), 64'(exp_hi));
    check("idle_flush_busy", 64'(busy), 64'd0);

    // Reserved op does nothing
    start = 1'b1; op = 3'd6; a = 32'h1111_2222; b = 32'd3;
    tick();
    start = 1'b0;
    check("rsvd_busy", 64'(busy), 64'd0);
    check("rsvd_hi", 64'(hi), 64'(exp_hi));
    check("rsvd_lo", 64'(lo), 64'(exp_lo));

    // Flush at E10
    start = 1'b1; op = 3'd0; a = 32'd5; b = 32'd5;
    tick();
    start = 1'b0;
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_done", 64'(done), 64'd0);
    nodone = 1'b1;
    repeat (40) begin tick(); nodone &= (done === 1'b0); end
    check("flush_no_done", 64'(nodone), 64'd1);
    check("flush_hi", 64'(hi), 64'(exp_hi));
    check("flush_lo", 64'(lo), 64'(exp_lo));
    run_op("multu_6x7", 3'd1, 32'd6, 32'd7, 1'b0);
    check("multu_6x7_lo_const", 64'(lo), 64'd42);

    // Flush on the FIX edge beats the write
    start = 1'b1; op = 3'd1; a = 32'hABCD; b = 32'h1234;
    tick();
    start = 1'b0;
    repeat (32) tick();
    check("fixflush_busy_pre", 64'(busy), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fixflush_done", 64'(done), 64'd0);
    check("fixflush_busy", 64'(busy), 64'd0);
    check("fixflush_hi", 64'(hi), 64'(exp_hi));
    check("fixflush_lo", 64'(lo), 64'(exp_lo));

    // Async reset mid-CALC, then a fresh DIVU
    start = 1'b1; op = 3'd3; a = 32'hFFFF_0000; b = 32'd3;
    tick();
    start = 1'b0;
    repeat (20) tick();
    #2 rst = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    check("arst_hi", 64'(hi), 64'd0);
    check("arst_lo", 64'(lo), 64'd0);
    exp_hi = 0; exp_lo = 0;
    tick();
    rst = 1'b1;
    tick();
    run_op("divu_9by4", 3'd3, 32'd9, 32'd4, 1'b0);
    check("divu_9by4_hi_const", 64'(hi), 64'd1);

    // Random ops
    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 3));
      rx = $urandom;
      ry = $urandom;
      r  = $urandom_range(0, 9);
      if (r == 0) ry = 0;
      if (r == 1) ry = $urandom_range(1, 15);
      if (r == 2) rx = 32'h8000_0000;
      if (r == 3) ry = 32'hFFFF_FFFF;
      run_op($sformatf("rand%0d_op%0d", i, ro), ro, rx, ry, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Multi-cycle multiply/divide unit that sits in the EX stage beside the ALU. It takes the same forwarded a/b operands the ALU receives and owns the architectural HI/LO registers. It performs signed and unsigned 32x32 multiply and 32/32 divide iteratively, one bit per cycle. While it works it drives busy so the hazard unit can stall the pipeline; it also services direct HI/LO writes (MTHI/MTLO).

Parameters:
WIDTH, 32, operand and HI/LO width; only 32 is supported and verified.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-low reset (0 = reset)
start  input  1  request to issue op with a/b, sampled at rising edge
op  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6/7 reserved (ignored)
a  input  32  operand rs (multiplicand / dividend / MTHI/MTLO data)
b  input  32  operand rt (multiplier / divisor)
flush  input  1  abort in-flight op (pipeline flush)
busy  output  1  op in flight; pipeline must stall HI/LO consumers and new muldiv issue
done  output  1  one-cycle pulse: HI/LO just updated by MULT/DIV result
hi  output  32  HI register
lo  output  32  LO register

Behaviour:
- Reset (rst=0, async): state=IDLE, busy=0, done=0, hi=0, lo=0, iteration counter=0. Takes effect immediately, including mid-operation; the partial result is discarded.
- States: IDLE, CALC, FIX. busy=1 exactly while state is CALC or FIX.
- IDLE, start=1, op 0..3, edge E0: latch operands, take magnitudes for signed ops (|0x80000000| = 0x80000000 unsigned), record result signs, counter=0, go to CALC.
- CALC: one iteration per edge, E1..E32.
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring; shift remainder, trial-subtract divisor, set quotient bit.
  - After 32 iterations, go to FIX.
- FIX, edge E33: apply sign correction and write HI/LO.
  - Multiply: {hi,lo}=64-bit product; negate if sign(a)^sign(b) for MULT.
  - DIV: quotient negated if sign(a)^sign(b); remainder takes sign of a.
  - Then go to IDLE.
  - done=1 for the single cycle after E33; busy drops after E33.
  - Total latency is 34 edges from issue to HI/LO valid.
- Divide by zero (b==0, op 2 or 3): run full timing regardless of signedness; result is lo=0xFFFFFFFF, hi=a (the original a, not its magnitude).
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0, no exception.
- MTHI/MTLO in IDLE with start=1: at the same edge write hi<=a or lo<=a; busy stays 0, done stays 0.
- start while busy: ignored for all ops; the issuing stage is stalled anyway.
- Reserved op with start=1: no state change.
- flush=1 at an edge while busy: return to IDLE, busy=0 next cycle, done=0, hi/lo unchanged.
- flush has priority over a FIX write at the same edge.
- flush while IDLE has priority over start: the op is dropped, including MTHI/MTLO.
- hi/lo change only on FIX, MTHI/MTLO, or reset; they hold all other cycles.
- done and busy are registered outputs, never combinational from start.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=7 -> busy high E0..E33; after E33 hi=0xFFFFFFFF, lo=0xFFFFFFEB; done pulses exactly 1 cycle.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU same operands -> lo=0x7FFFFFFC, hi=0x00000001.
- Boundaries: DIVU a=100, b=0 -> lo=0xFFFFFFFF, hi=0x00000064, 34-edge timing; DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI a=0x12345678 in IDLE -> hi=0x12345678 next cycle, busy=0, done=0; MTLO issued while a MULT is busy -> ignored, lo shows MULT result only.
- Flush: issue MULT 5*5, assert flush at E10 -> busy=0 next cycle, hi/lo keep prior values, no done; new MULTU 6*7 then completes with lo=42, hi=0.
- Async reset: drop rst mid-cycle during CALC (E20) -> busy, done, hi, lo all 0 immediately without a clock edge; after release a fresh DIVU 9/4 gives lo=2, hi=1.
